// File: rtl/bsg_manycore_pkg.sv
// Shared manycore packet definitions: op encoding, packet layout and
// offsets of the load return address carried in the data field.
package bsg_manycore_pkg;

    typedef enum logic [1:0] {
        e_op_load   = 2'b00,
        e_op_store  = 2'b01,
        e_op_rsvd_2 = 2'b10,
        e_op_rsvd_3 = 2'b11
    } bsg_manycore_op_e;

    // Default-geometry packet layout; parameterized modules rebuild it locally
    localparam int unsigned x_cord_width_gp = 5;
    localparam int unsigned y_cord_width_gp = 5;
    localparam int unsigned data_width_gp   = 32;
    localparam int unsigned addr_width_gp   = 32;

    typedef struct packed {
        bsg_manycore_op_e             op;
        logic [data_width_gp/8-1:0]   op_ex;
        logic [addr_width_gp-1:0]     addr;
        logic [data_width_gp-1:0]     data;
        logic [y_cord_width_gp-1:0]   y_cord;
        logic [x_cord_width_gp-1:0]   x_cord;
    } bsg_manycore_packet_s;

    localparam int unsigned ret_x_offset_gp = 0;

    function automatic int unsigned ret_y_offset(input int unsigned x_cord_width);
        return x_cord_width;
    endfunction

    function automatic int unsigned bsg_manycore_packet_width(
        input int unsigned addr_w,
        input int unsigned data_w,
        input int unsigned x_w,
        input int unsigned y_w
    );
        return 2 + data_w/8 + addr_w + data_w + y_w + x_w;
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous SRAM with per-byte write enables; contents not reset.
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int width_p       = 32,
    parameter int els_p         = 1024,
    parameter int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p/8-1:0]     write_mask_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (v_i & w_i) begin
            for (int unsigned i = 0; i < width_p/8; i++) begin
                if (write_mask_i[i]) mem_r[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
            end
        end
        if (v_i & ~w_i) data_o <= mem_r[addr_i];
    end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry valid/ready FIFO with yumi-style dequeue; not ready during reset.
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [1:0]         count_r;
    logic               enq;

    assign ready_o = ~reset_i & (count_r != 2'd2);
    assign v_o     = (count_r != 2'd0);
    assign data_o  = mem_r[rd_ptr_r];
    assign enq     = v_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (enq)    wr_ptr_r <= ~wr_ptr_r;
            if (yumi_i) rd_ptr_r <= ~rd_ptr_r;
            count_r <= count_r + {1'b0, enq} - {1'b0, yumi_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wr_ptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_manycore_mem_responder.sv
// Edge memory endpoint: applies remote stores to a local SRAM and answers
// remote loads with a store packet addressed back to the requester.
module bsg_manycore_mem_responder
    import bsg_manycore_pkg::*;
#(
    parameter int x_cord_width_p  = 5,
    parameter int y_cord_width_p  = 5,
    parameter int data_width_p    = 32,
    parameter int addr_width_p    = 32,
    parameter int els_p           = 1024,
    parameter int packet_width_lp = bsg_manycore_packet_width(addr_width_p, data_width_p,
                                                              x_cord_width_p, y_cord_width_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    input  logic [packet_width_lp-1:0] data_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [packet_width_lp-1:0] data_o,
    input  logic                       ready_i,
    input  logic [x_cord_width_p-1:0]  my_x_i,
    input  logic [y_cord_width_p-1:0]  my_y_i,
    output logic                       err_o,
    output logic [15:0]                err_cnt_o
);

    localparam int mask_width_lp = data_width_p/8;
    localparam int lg_els_lp     = $clog2(els_p);

    typedef struct packed {
        bsg_manycore_op_e            op;
        logic [mask_width_lp-1:0]    op_ex;
        logic [addr_width_p-1:0]     addr;
        logic [data_width_p-1:0]     data;
        logic [y_cord_width_p-1:0]   y_cord;
        logic [x_cord_width_p-1:0]   x_cord;
    } packet_s;

    typedef enum logic [1:0] {e_idle, e_read, e_resp} state_e;

    state_e                    state_r, state_n;
    packet_s                   fifo_data, resp_r;
    logic                      fifo_v, fifo_yumi;
    logic                      sram_v, sram_w;
    logic [data_width_p-1:0]   sram_data;
    logic                      drop, drop_event, load_issue;
    logic                      err_r;
    logic [15:0]               err_cnt_r;

    bsg_two_fifo #(.width_p(packet_width_lp)) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (fifo_yumi)
    );

    bsg_mem_1rw_sync_mask_write_byte #(.width_p(data_width_p), .els_p(els_p)) mem (
        .clk_i        (clk_i),
        .v_i          (sram_v),
        .w_i          (sram_w),
        .addr_i       (fifo_data.addr[lg_els_lp-1:0]),
        .data_i       (fifo_data.data),
        .write_mask_i (fifo_data.op_ex),
        .data_o       (sram_data)
    );

    assign drop = ({fifo_data.y_cord, fifo_data.x_cord} != {my_y_i, my_x_i})
               || (fifo_data.op == e_op_rsvd_2) || (fifo_data.op == e_op_rsvd_3);

    always_comb begin
        state_n    = state_r;
        fifo_yumi  = 1'b0;
        sram_v     = 1'b0;
        sram_w     = 1'b0;
        drop_event = 1'b0;
        load_issue = 1'b0;
        case (state_r)
            e_idle: if (fifo_v) begin
                fifo_yumi = 1'b1;
                if (drop) begin
                    drop_event = 1'b1;
                end else if (fifo_data.op == e_op_store) begin
                    sram_v = 1'b1;
                    sram_w = 1'b1;
                end else begin
                    sram_v     = 1'b1;
                    load_issue = 1'b1;
                    state_n    = e_read;
                end
            end
            e_read: state_n = e_resp;
            e_resp: if (ready_i) state_n = e_idle;
            default: state_n = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= e_idle;
            err_r     <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            state_r <= state_n;
            if (drop_event) begin
                err_r <= 1'b1;
                if (err_cnt_r != '1) err_cnt_r <= err_cnt_r + 16'd1;
            end
        end
    end

    // Header is latched at dequeue; the SRAM word joins it one cycle later
    always_ff @(posedge clk_i) begin
        if (load_issue) begin
            resp_r.op     <= e_op_store;
            resp_r.op_ex  <= '1;
            resp_r.addr   <= fifo_data.addr;
            resp_r.x_cord <= fifo_data.data[ret_x_offset_gp +: x_cord_width_p];
            resp_r.y_cord <= fifo_data.data[ret_y_offset(x_cord_width_p) +: y_cord_width_p];
        end
        if (state_r == e_read) resp_r.data <= sram_data;
    end

    assign v_o       = (state_r == e_resp);
    assign data_o    = resp_r;
    assign err_o     = err_r;
    assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// Directed table-driven bench for bsg_manycore_mem_responder plus latency,
// back-pressure and mid-load reset sequences.
module tb_bsg_manycore_mem_responder;
    import bsg_manycore_pkg::*;

    localparam int PW = bsg_manycore_packet_width(32, 32, 5, 5);

    logic          clk = 1'b0;
    logic          reset_i, v_i, ready_o, v_o, ready_i, err_o;
    logic [PW-1:0] data_i, data_o;
    logic [4:0]    my_x, my_y;
    logic [15:0]   err_cnt_o;

    int n_vec = 0;
    int n_bad = 0;

    bsg_manycore_mem_responder dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .ready_i   (ready_i),
        .my_x_i    (my_x),
        .my_y_i    (my_y),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  x;
        logic [4:0]  y;
        bit          resp;
        logic [31:0] exp_data;
        logic [4:0]  exp_x;
        logic [4:0]  exp_y;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bsg_manycore_packet_s mk(input logic [1:0] op, input logic [3:0] mask,
                                                input logic [31:0] addr, input logic [31:0] data,
                                                input logic [4:0] y, input logic [4:0] x);
        bsg_manycore_packet_s p;
        p.op     = bsg_manycore_op_e'(op);
        p.op_ex  = mask;
        p.addr   = addr;
        p.data   = data;
        p.y_cord = y;
        p.x_cord = x;
        return p;
    endfunction

    function automatic logic [31:0] ret(input logic [4:0] x, input logic [4:0] y);
        return {22'b0, y, x};
    endfunction

    // Called at a negedge; returns at the negedge after the packet is accepted
    task automatic send(input bsg_manycore_packet_s p);
        int n = 0;
        v_i    = 1'b1;
        data_i = p;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send ready timeout", ready_o, 1);
        @(negedge clk);
        v_i = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [4:0] x, input logic [4:0] y);
        bsg_manycore_packet_s r;
        int n = 0;
        while (!v_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " v_o"}, v_o, 1);
        r = data_o;
        chk({tag, " data"}, r.data, data);
        chk({tag, " x"}, r.x_cord, x);
        chk({tag, " y"}, r.y_cord, y);
        chk({tag, " op"}, r.op, 2'b01);
        chk({tag, " op_ex"}, r.op_ex, 4'hF);
        chk({tag, " addr"}, r.addr, addr);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bsg_manycore_packet_s exp_p;
        vecs[0]  = '{2'b01, 4'hF, 32'd5,    32'hDEADBEEF, 5'd4, 5'd7, 1'b0, 32'h0,        5'd0,  5'd0,  16'd0};
        vecs[1]  = '{2'b00, 4'hF, 32'd5,    ret(2, 0),    5'd4, 5'd7, 1'b1, 32'hDEADBEEF, 5'd2,  5'd0,  16'd0};
        vecs[2]  = '{2'b01, 4'h1, 32'd5,    32'h000000AA, 5'd4, 5'd7, 1'b0, 32'h0,        5'd0,  5'd0,  16'd0};
        vecs[3]  = '{2'b00, 4'hF, 32'd5,    ret(3, 1),    5'd4, 5'd7, 1'b1, 32'hDEADBEAA, 5'd3,  5'd1,  16'd0};
        vecs[4]  = '{2'b01, 4'hF, 32'd3,    32'h11223344, 5'd4, 5'd7, 1'b0, 32'h0,        5'd0,  5'd0,  16'd0};
        vecs[5]  = '{2'b00, 4'hF, 32'd1027, ret(5, 6),    5'd4, 5'd7, 1'b1, 32'h11223344, 5'd5,  5'd6,  16'd0};
        vecs[6]  = '{2'b01, 4'hF, 32'd9,    32'hCAFEF00D, 5'd4, 5'd7, 1'b0, 32'h0,        5'd0,  5'd0,  16'd0};
        vecs[7]  = '{2'b01, 4'h6, 32'd9,    32'h55667788, 5'd4, 5'd7, 1'b0, 32'h0,        5'd0,  5'd0,  16'd0};
        vecs[8]  = '{2'b00, 4'hF, 32'd9,    ret(31, 31),  5'd4, 5'd7, 1'b1, 32'hCA66770D, 5'd31, 5'd31, 16'd0};
        vecs[9]  = '{2'b01, 4'hF, 32'd5,    32'h0,        5'd5, 5'd7, 1'b0, 32'h0,        5'd0,  5'd0,  16'd1};
        vecs[10] = '{2'b11, 4'hF, 32'd5,    32'h0,        5'd4, 5'd7, 1'b0, 32'h0,        5'd0,  5'd0,  16'd2};
        vecs[11] = '{2'b00, 4'hF, 32'd5,    ret(0, 0),    5'd4, 5'd7, 1'b1, 32'hDEADBEAA, 5'd0,  5'd0,  16'd2};

        my_x    = 5'd4;
        my_y    = 5'd7;
        reset_i = 1'b1;
        v_i     = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;
        repeat (2) @(negedge clk);
        chk("reset ready_o", ready_o, 0);
        chk("reset v_o", v_o, 0);
        chk("reset err_o", err_o, 0);
        chk("reset err_cnt", err_cnt_o, 0);
        reset_i = 1'b0;
        @(negedge clk);
        chk("ready after reset", ready_o, 1);

        for (int i = 0; i < 12; i++) begin
            send(mk(vecs[i].op, vecs[i].mask, vecs[i].addr, vecs[i].data, vecs[i].y, vecs[i].x));
            if (vecs[i].resp) begin
                wait_resp($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_data,
                          vecs[i].exp_x, vecs[i].exp_y);
            end else begin
                repeat (2) @(negedge clk);
                chk($sformatf("vec%0d no resp", i), v_o, 0);
            end
            chk($sformatf("vec%0d err_cnt", i), err_cnt_o, vecs[i].exp_cnt);
            chk($sformatf("vec%0d err_o", i), err_o, vecs[i].exp_cnt != 0);
        end

        // Load latency: dequeue cycle t, v_o in t+2
        send(mk(2'b00, 4'hF, 32'd3, ret(1, 2), 5'd7, 5'd4));
        chk("lat t", v_o, 0);
        @(negedge clk);
        chk("lat t+1", v_o, 0);
        @(negedge clk);
        chk("lat t+2", v_o, 1);
        wait_resp("lat", 32'd3, 32'h11223344, 5'd1, 5'd2);

        // Back-pressure: three stores queued behind a stalled response
        ready_i = 1'b0;
        exp_p   = mk(2'b01, 4'hF, 32'd3, 32'h11223344, 5'd1, 5'd1);
        send(mk(2'b00, 4'hF, 32'd3, ret(1, 1), 5'd7, 5'd4));
        v_i    = 1'b1;
        data_i = mk(2'b01, 4'hF, 32'd20, 32'h1, 5'd7, 5'd4);
        @(negedge clk);
        data_i = mk(2'b01, 4'hF, 32'd21, 32'h2, 5'd7, 5'd4);
        @(negedge clk);
        data_i = mk(2'b01, 4'hF, 32'd20, 32'h3, 5'd7, 5'd4);
        chk("bp ready_o full", ready_o, 0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp v_o %0d", k), v_o, 1);
            chk($sformatf("bp data_o %0d", k), data_o, exp_p);
            chk($sformatf("bp ready_o %0d", k), ready_o, 0);
            @(negedge clk);
        end
        ready_i = 1'b1;
        send(mk(2'b01, 4'hF, 32'd20, 32'h3, 5'd7, 5'd4));
        repeat (3) @(negedge clk);
        send(mk(2'b00, 4'hF, 32'd20, ret(2, 3), 5'd7, 5'd4));
        wait_resp("bp a20", 32'd20, 32'h3, 5'd2, 5'd3);
        send(mk(2'b00, 4'hF, 32'd21, ret(2, 3), 5'd7, 5'd4));
        wait_resp("bp a21", 32'd21, 32'h2, 5'd2, 5'd3);

        // Reset while in READ discards the pending response
        send(mk(2'b00, 4'hF, 32'd5, ret(2, 0), 5'd7, 5'd4));
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        chk("rst v_o", v_o, 0);
        chk("rst err_o", err_o, 0);
        chk("rst err_cnt", err_cnt_o, 0);
        chk("rst ready_o", ready_o, 0);
        reset_i = 1'b0;
        @(negedge clk);
        chk("rst v_o after", v_o, 0);
        chk("rst ready_o after", ready_o, 1);
        send(mk(2'b00, 4'hF, 32'd5, ret(6, 9), 5'd7, 5'd4));
        wait_resp("post rst", 32'd5, 32'hDEADBEAA, 5'd6, 5'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
